// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants and the receiver FSM state type for uart_rx_fifo.
//   OVERSAMPLE : oversample ticks per bit time
//   MID_SAMPLE : ticks from the start edge to the middle of the start bit
//   DATA_BITS  : payload bits per frame
//   rx_state_t : receiver FSM states. The PARITY state exists only when
//                UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd4,
`endif
        STOP   = 3'd3
    } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// The head entry is presented on rd_data whenever the FIFO is not empty.
// rd_data reads as zero while empty.
// A write while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   wr_en       : write request
//   wr_data     : data to write
//   rd_en       : pop the head entry; ignored while empty
//   rd_data     : head entry
//   count       : occupancy, 0..DEPTH
//   full, empty : occupancy flags
// DEPTH must be a power of two and at least 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    // DEPTH is a power of two, so the count MSB is set only at DEPTH.
    assign full    = count[AW];
    assign do_pop  = rd_en & ~empty;
    assign do_push = wr_en & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with 16x oversampling and a
// first-word-fall-through receive FIFO.
// Optional macro UART_RX_PARITY_EN adds the following:
//   - a parity bit after the data bits;
//   - the parity_odd input and the parity_err output.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   baud_div     : clk cycles per oversample tick (0 behaves as 1)
//   rxd          : asynchronous serial input, idle high
//   rd_en        : pop the FIFO head
//   rd_data      : FIFO head byte (zero while empty)
//   rx_valid     : FIFO not empty
//   fifo_count   : FIFO occupancy
//   frame_err    : sticky, stop bit sampled low
//   overrun_err  : sticky, byte arrived while FIFO full
//   err_clr      : clear sticky error flags (a same-cycle set wins)
//   parity_odd   : [UART_RX_PARITY_EN] 1 = odd parity, 0 = even parity
//   parity_err   : [UART_RX_PARITY_EN] sticky, parity mismatch
//   irq          : rx_valid or any sticky error
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic                        rxd,
    input  logic                        rd_en,
    output logic [7:0]                  rd_data,
    output logic                        rx_valid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun_err,
    input  logic                        err_clr,
`ifdef UART_RX_PARITY_EN
    input  logic                        parity_odd,
    output logic                        parity_err,
`endif
    output logic                        irq
);

    localparam logic [3:0]       MID_LAST = 4'(MID_SAMPLE - 1);
    localparam logic [3:0]       BIT_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic             rxd_meta, rxd_s, rxd_prev, fall;
    logic [DIV_W-1:0] div_cnt, div_max;
    logic             tick;
    rx_state_t        state, state_n;
    logic [3:0]       tcnt, tcnt_n;
    logic [2:0]       bidx, bidx_n;
    logic [7:0]       shreg, shreg_n;
    logic             brk, brk_n;
    logic             start_edge, push, frame_set, overrun_set;
    logic             fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
    logic             par_bad, par_bad_n, parity_set;
`endif

    // Input synchronizer: flops reset to the idle level so that reset does not fake a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end
    assign fall = rxd_prev & ~rxd_s;

    // Oversample tick generator. The >= compare lets a smaller divisor take
    // effect at the next wrap instead of running the counter past it.
    assign div_max = (baud_div == '0) ? DIV_ONE : baud_div;
    assign tick    = (div_cnt >= div_max - DIV_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  div_cnt <= '0;
        else if (start_edge || tick) div_cnt <= '0;
        else                         div_cnt <= div_cnt + DIV_ONE;
    end

    // Receiver FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tcnt  <= '0;
            bidx  <= '0;
            brk   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state <= state_n;
            tcnt  <= tcnt_n;
            bidx  <= bidx_n;
            brk   <= brk_n;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_n;
`endif
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    // Receiver FSM: next state and per-cycle events
    always_comb begin
        state_n    = state;
        tcnt_n     = tcnt;
        bidx_n     = bidx;
        shreg_n    = shreg;
        brk_n      = brk;
        start_edge = 1'b0;
        push       = 1'b0;
        frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n  = par_bad;
        parity_set = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (fall) begin
                    start_edge = 1'b1;
                    tcnt_n     = '0;
                    state_n    = START;
                end
            end
            START: begin
                if (tick) begin
                    if (tcnt == MID_LAST) begin
                        tcnt_n = '0;
                        if (!rxd_s) begin
                            bidx_n  = '0;
                            state_n = DATA;
`ifdef UART_RX_PARITY_EN
                            par_bad_n = 1'b0;
`endif
                        end else begin
                            // Start bit not low at mid-bit: treat it as a glitch.
                            state_n = IDLE;
                        end
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tcnt == BIT_LAST) begin
                        tcnt_n  = '0;
                        shreg_n = {rxd_s, shreg[7:1]};
                        if (bidx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            bidx_n = bidx + 1'b1;
                        end
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tcnt == BIT_LAST) begin
                        tcnt_n     = '0;
                        par_bad_n  = ((^shreg) ^ rxd_s) != parity_odd;
                        parity_set = par_bad_n;
                        state_n    = STOP;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (brk) begin
                    // Framing error: hold here until the line returns high.
                    if (rxd_s) begin
                        brk_n   = 1'b0;
                        state_n = IDLE;
                    end
                end else if (tick) begin
                    if (tcnt == BIT_LAST) begin
                        tcnt_n = '0;
                        if (rxd_s) begin
`ifdef UART_RX_PARITY_EN
                            push = ~par_bad;
`else
                            push = 1'b1;
`endif
                            state_n = IDLE;
                        end else begin
                            frame_set = 1'b1;
                            brk_n     = 1'b1;
                        end
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (shreg),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rx_valid = ~fifo_empty;

    // A same-cycle pop makes room, so only a push into a full FIFO without a pop is an overrun.
    assign overrun_set = push & fifo_full & ~rd_en;

    // Sticky error flags: set wins over err_clr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_err   <= frame_set   | (frame_err   & ~err_clr);
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
`ifdef UART_RX_PARITY_EN
            parity_err  <= parity_set  | (parity_err  & ~err_clr);
`endif
        end
    end

`ifdef UART_RX_PARITY_EN
    assign irq = rx_valid | frame_err | overrun_err | parity_err;
`else
    assign irq = rx_valid | frame_err | overrun_err;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: self-checking bench for uart_rx_fifo (default 8N1 build).
// A queue-based reference model tracks FIFO contents and sticky flags from
// the frame-level rules; a vector table covers single frames at several divisors.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] baud_div;
    logic        rxd;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rx_valid;
    logic [4:0]  fifo_count;
    logic        frame_err;
    logic        overrun_err;
    logic        err_clr;
    logic        irq;

    int tests = 0;
    int fails = 0;

    logic [7:0] mq[$];
    logic       m_ferr;
    logic       m_ovr;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] bd;
        logic        stop_val;
        logic        exp_valid;
        logic [7:0]  exp_head;
        logic        exp_ferr;
    } vec_t;

    vec_t vt[6];

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .baud_div    (baud_div),
        .rxd         (rxd),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rx_valid    (rx_valid),
        .fifo_count  (fifo_count),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .err_clr     (err_clr),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] head;
        head = (mq.size() > 0) ? mq[0] : 8'h00;
        chk({tag, " rx_valid"},    32'(rx_valid),    32'(mq.size() > 0));
        chk({tag, " fifo_count"},  32'(fifo_count),  32'(mq.size()));
        chk({tag, " rd_data"},     32'(rd_data),     32'(head));
        chk({tag, " frame_err"},   32'(frame_err),   32'(m_ferr));
        chk({tag, " overrun_err"}, 32'(overrun_err), 32'(m_ovr));
        chk({tag, " irq"},         32'(irq),         32'((mq.size() > 0) || m_ferr || m_ovr));
    endtask

    // Frame outcome from the spec rules: a same-cycle pop happens first,
    // a same-cycle clear loses to a new error.
    task automatic model_frame(input logic [7:0] b, input logic stop_ok,
                               input logic pop, input logic clr);
        if (pop && mq.size() > 0) void'(mq.pop_front());
        if (clr) begin
            m_ferr = 1'b0;
            m_ovr  = 1'b0;
        end
        if (!stop_ok)                m_ferr = 1'b1;
        else if (mq.size() >= DEPTH) m_ovr  = 1'b1;
        else                         mq.push_back(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop1();
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
    endtask

    task automatic clr_err();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Drives one frame; the stop level lasts stop_bits bit times, then the line idles high.
    // With a bit time of 16*bd clocks, the start edge is seen two clocks after the line falls.
    // The stop bit is sampled 152 ticks later, so the push lands on clock edge 3 + 152*bd
    // counted from the start of the frame.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_bits,
                              input logic pop_at_push, input logic clr_at_push,
                              output logic v_pre, output logic v_post);
        int bd_eff, bitc, n, push_cyc, bi;
        bd_eff   = (baud_div == 16'd0) ? 1 : int'(baud_div);
        bitc     = 16 * bd_eff;
        push_cyc = 3 + 152 * bd_eff;
        n        = (9 + stop_bits) * bitc;
        v_pre    = 1'b0;
        v_post   = 1'b0;
        for (int c = 0; c < n; c++) begin
            bi = c / bitc;
            if (bi == 0)      rxd = 1'b0;
            else if (bi <= 8) rxd = b[3'(bi - 1)];
            else              rxd = stop_val;
            if (c + 1 == push_cyc) begin
                if (pop_at_push) rd_en   = 1'b1;
                if (clr_at_push) err_clr = 1'b1;
            end
            @(posedge clk);
            #1;
            if (c + 1 == push_cyc) begin
                rd_en   = 1'b0;
                err_clr = 1'b0;
                v_post  = rx_valid;
            end
            if (c + 1 == push_cyc - 1) v_pre = rx_valid;
        end
        rxd = 1'b1;
    endtask

    initial begin
        logic       vp, vq, d1, d2;
        logic [7:0] b;
        logic       ok;
        logic [7:0] b2b [3];

        rst_n    = 1'b0;
        rxd      = 1'b1;
        rd_en    = 1'b0;
        err_clr  = 1'b0;
        baud_div = 16'd4;
        m_ferr   = 1'b0;
        m_ovr    = 1'b0;

        vt[0] = '{8'h01, 16'd1, 1'b1, 1'b1, 8'h01, 1'b0};
        vt[1] = '{8'h80, 16'd2, 1'b1, 1'b1, 8'h80, 1'b0};
        vt[2] = '{8'hC3, 16'd0, 1'b1, 1'b1, 8'hC3, 1'b0};
        vt[3] = '{8'h5A, 16'd3, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[4] = '{8'hFE, 16'd1, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[5] = '{8'h96, 16'd5, 1'b1, 1'b1, 8'h96, 1'b0};

        idle(3);
        check_model("reset");
        rst_n = 1'b1;
        idle(5);

        // Single byte at baud_div=4 with push timing.
        send_frame(8'hA5, 1'b1, 1, 1'b0, 1'b0, vp, vq);
        chk("a5 valid before push edge", 32'(vp), 32'(0));
        chk("a5 valid after push edge",  32'(vq), 32'(1));
        model_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check_model("a5");
        pop1();
        check_model("a5 popped");

        // Back-to-back frames with no idle gap.
        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        b2b[2] = 8'h55;
        for (int i = 0; i < 3; i++) begin
            send_frame(b2b[i], 1'b1, 1, 1'b0, 1'b0, vp, vq);
            model_frame(b2b[i], 1'b1, 1'b0, 1'b0);
        end
        check_model("b2b");
        for (int i = 0; i < 3; i++) begin
            pop1();
            check_model("b2b pop");
        end

        // Short low glitch: no push, no error, receiver still usable.
        rxd = 1'b0;
        idle(20);
        rxd = 1'b1;
        idle(100);
        check_model("glitch");

        // Stop bit held low for two bit times.
        send_frame(8'h3C, 1'b0, 2, 1'b0, 1'b0, vp, vq);
        model_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check_model("frame err");
        idle(4);
        clr_err();
        check_model("frame err cleared");
        idle(40);
        check_model("frame err stays clear");

        // Vector table, each entry from an empty FIFO with clear flags.
        for (int i = 0; i < 6; i++) begin
            baud_div = vt[i].bd;
            idle(2);
            send_frame(vt[i].data, vt[i].stop_val, 1, 1'b0, 1'b0, vp, vq);
            chk($sformatf("vec%0d rx_valid", i),   32'(rx_valid),   32'(vt[i].exp_valid));
            chk($sformatf("vec%0d rd_data", i),    32'(rd_data),    32'(vt[i].exp_head));
            chk($sformatf("vec%0d frame_err", i),  32'(frame_err),  32'(vt[i].exp_ferr));
            chk($sformatf("vec%0d fifo_count", i), 32'(fifo_count), 32'(vt[i].exp_valid));
            pop1();
            clr_err();
            idle(5);
        end
        check_model("after table");

        // Randomized frames against the reference model.
        for (int i = 0; i < 24; i++) begin
            baud_div = 16'($urandom_range(0, 3));
            b  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            send_frame(b, ok, 1, 1'b0, 1'b0, vp, vq);
            model_frame(b, ok, 1'b0, 1'b0);
            idle(4);
            check_model($sformatf("rand%0d", i));
            if ($urandom_range(0, 2) == 0) pop1();
            if ($urandom_range(0, 4) == 0) clr_err();
        end
        for (int i = 0; i < DEPTH; i++) pop1();
        clr_err();
        check_model("rand drained");

        // Fill, overrun, pop-then-push at full, clear-versus-set at full.
        baud_div = 16'd1;
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'(i * 17 + 3);
            send_frame(b, 1'b1, 1, 1'b0, 1'b0, vp, vq);
            model_frame(b, 1'b1, 1'b0, 1'b0);
        end
        check_model("full16");
        send_frame(8'hEE, 1'b1, 1, 1'b0, 1'b0, vp, vq);
        model_frame(8'hEE, 1'b1, 1'b0, 1'b0);
        check_model("overrun");
        clr_err();
        send_frame(8'h42, 1'b1, 1, 1'b1, 1'b0, vp, vq);
        model_frame(8'h42, 1'b1, 1'b1, 1'b0);
        check_model("pop at push full");
        send_frame(8'h99, 1'b1, 1, 1'b0, 1'b1, vp, vq);
        model_frame(8'h99, 1'b1, 1'b0, 1'b1);
        check_model("clr vs overrun set");

        // Reset in the middle of a frame's data bits.
        baud_div = 16'd4;
        fork
            send_frame(8'hFF, 1'b1, 1, 1'b0, 1'b0, d1, d2);
            begin
                idle(200);
                rst_n = 1'b0;
                #1;
                mq.delete();
                m_ferr = 1'b0;
                m_ovr  = 1'b0;
                check_model("in reset");
                idle(3);
                rst_n = 1'b1;
            end
        join
        idle(10);
        check_model("after reset frame");
        send_frame(8'h7E, 1'b1, 1, 1'b0, 1'b0, vp, vq);
        model_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        check_model("7e after reset");
        pop1();
        check_model("7e popped");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
